// File: rtl/aes_word_packer_pkg.sv
// Shared types and widths for the AES streamer word packer and its control FSM.
package aes_package;

  localparam int AES_WORD_W  = 32;
  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_FILL = 2'd1,
    G_HOLD = 2'd2
  } aes_gather_state_t;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } aes_scatter_state_t;

  typedef struct packed {
    logic        start;
    logic        clear;
    logic        enable;
    logic [15:0] nblocks;
  } ctrl_packer_t;

  typedef struct packed {
    logic busy;
    logic done;
  } flags_packer_t;

endpackage

// File: rtl/aes_word_packer.sv
// Gathers streamer words into cipher blocks and scatters cipher results back into words,
// counting a fixed number of blocks per job.
module aes_word_packer
  import aes_package::*;
#(
  parameter int WORD_W  = AES_WORD_W,
  parameter int BLOCK_W = AES_BLOCK_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               enable,
  input  logic               start,
  input  logic [15:0]        nblocks,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [BLOCK_W-1:0] blk_data,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [BLOCK_W-1:0] res_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data
);

  localparam int NWORDS = BLOCK_W / WORD_W;
  localparam int CNT_W  = $clog2(NWORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

  aes_gather_state_t  g_state;
  aes_scatter_state_t s_state;
  logic [CNT_W-1:0]   g_wcnt;
  logic [CNT_W-1:0]   s_wcnt;
  logic [15:0]        g_bcnt;
  logic [15:0]        s_bcnt;
  logic [15:0]        nblocks_r;
  logic [BLOCK_W-1:0] blk_r;
  logic [BLOCK_W-1:0] res_r;
  logic               busy_r;
  logic               done_r;

  logic               start_ok;
  logic               in_fire;
  logic               res_fire;
  logic               out_fire;
  logic [15:0]        g_bcnt_next;
  logic [15:0]        s_bcnt_next;
  logic               job_last;

  assign start_ok    = start && !busy_r;
  assign in_ready    = (g_state == G_FILL) && enable;
  assign blk_valid   = (g_state == G_HOLD);
  assign blk_data    = blk_r;
  assign res_ready   = (s_state == S_IDLE) && busy_r && enable;
  assign out_valid   = (s_state == S_DRAIN);
  assign out_data    = res_r[BLOCK_W-1 -: WORD_W];
  assign busy        = busy_r;
  assign done        = done_r;

  assign in_fire     = in_valid && in_ready;
  assign res_fire    = res_valid && res_ready;
  assign out_fire    = out_valid && out_ready;
  assign g_bcnt_next = g_bcnt + 16'd1;
  assign s_bcnt_next = s_bcnt + 16'd1;
  assign job_last    = out_fire && (s_wcnt == LAST_WORD) && (s_bcnt_next == nblocks_r);

  // Job control: latch the block count, track busy and pulse done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      nblocks_r <= 16'd0;
    end else if (clear) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      nblocks_r <= 16'd0;
    end else begin
      done_r <= 1'b0;
      if (start_ok) begin
        nblocks_r <= nblocks;
        // An empty job completes at once without ever reporting busy.
        if (nblocks == 16'd0) begin
          done_r <= 1'b1;
        end else begin
          busy_r <= 1'b1;
        end
      end else if (job_last) begin
        done_r <= 1'b1;
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  // Gather: shift words in MSW first, then hold the block until the core takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_state <= G_IDLE;
      g_wcnt  <= '0;
      g_bcnt  <= 16'd0;
      blk_r   <= '0;
    end else if (clear) begin
      g_state <= G_IDLE;
      g_wcnt  <= '0;
      g_bcnt  <= 16'd0;
      blk_r   <= '0;
    end else begin
      case (g_state)
        G_IDLE: begin
          if (start_ok && (nblocks != 16'd0)) begin
            g_state <= G_FILL;
            g_wcnt  <= '0;
            g_bcnt  <= 16'd0;
          end
        end
        G_FILL: begin
          if (in_fire) begin
            blk_r  <= {blk_r[BLOCK_W-WORD_W-1:0], in_data};
            g_wcnt <= g_wcnt + CNT_W'(1);
            if (g_wcnt == LAST_WORD) begin
              g_state <= G_HOLD;
            end
          end
        end
        G_HOLD: begin
          if (blk_ready) begin
            g_bcnt  <= g_bcnt_next;
            g_state <= (g_bcnt_next == nblocks_r) ? G_IDLE : G_FILL;
          end
        end
        default: g_state <= G_IDLE;
      endcase
    end
  end

  // Scatter: latch a result block and shift it out one word per handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_state <= S_IDLE;
      s_wcnt  <= '0;
      s_bcnt  <= 16'd0;
      res_r   <= '0;
    end else if (clear) begin
      s_state <= S_IDLE;
      s_wcnt  <= '0;
      s_bcnt  <= 16'd0;
      res_r   <= '0;
    end else begin
      case (s_state)
        S_IDLE: begin
          if (start_ok) begin
            s_wcnt <= '0;
            s_bcnt <= 16'd0;
          end else if (res_fire) begin
            res_r   <= res_data;
            s_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_fire) begin
            res_r  <= res_r << WORD_W;
            s_wcnt <= s_wcnt + CNT_W'(1);
            if (s_wcnt == LAST_WORD) begin
              s_bcnt  <= s_bcnt_next;
              s_state <= S_IDLE;
            end
          end
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_word_packer.sv
// Self-checking bench for aes_word_packer: table-driven jobs against a queue-based
// reference model, plus hand sequences for restart, clear and enable corner cases.
module tb_aes_word_packer;
  import aes_package::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clear = 1'b0, enable = 1'b0, start = 1'b0;
  logic [15:0]  nblocks = 16'd0;
  logic         busy, done;
  logic         in_valid = 1'b0, in_ready;
  logic [31:0]  in_data = 32'd0;
  logic         blk_valid, blk_ready = 1'b0;
  logic [127:0] blk_data;
  logic         res_valid = 1'b0, res_ready;
  logic [127:0] res_data = 128'd0;
  logic         out_valid, out_ready = 1'b0;
  logic [31:0]  out_data;

  always #5 clk = ~clk;

  aes_word_packer dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable), .start(start),
    .nblocks(nblocks), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  typedef struct {
    int n; bit bp; bit cont; int exp_xfers; int exp_inr_low; int exp_done;
  } vec_t;

  int tests = 0, fails = 0;

  // Reference model: words to send, expected blocks, expected output words, core FIFO.
  logic [31:0]  in_words[$];
  logic [127:0] exp_blk[$];
  logic [31:0]  exp_out[$];
  logic [127:0] core_q[$];
  logic [31:0]  out_log[$];
  logic [127:0] core_key = 128'd0;
  logic [127:0] last_blk = 128'd0, prev_blk = 128'd0;
  logic [31:0]  prev_out = 32'd0;
  logic [31:0]  fixed_w[4];

  int  in_cnt, blk_cnt, out_cnt, done_cnt, cyc = 0;
  int  last_out_cyc, done_cyc, busy_seen, inr_low, start_cyc;
  int  last_in_cyc, blk_rise_cyc, res_fire_cyc, out_rise_cyc;
  bit  bp = 1'b0, cont = 1'b1, hold_blk = 1'b0, in_keep = 1'b0;
  bit  blk_stall = 1'b0, out_stall = 1'b0;
  bit  en_ctl = 1'b1, start_ctl = 1'b0, clear_ctl = 1'b0;
  logic [15:0] nb_ctl = 16'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, then observe outputs and upcoming handshakes.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    enable  = en_ctl;
    start   = start_ctl;
    nblocks = nb_ctl;
    clear   = clear_ctl;
    if (!in_keep) begin
      in_valid = (in_cnt < in_words.size()) && (cont || ($urandom_range(0, 1) == 1));
      if (in_valid) in_data = in_words[in_cnt];
      else          in_data = $urandom();
    end
    blk_ready = !hold_blk && (!bp || ($urandom_range(0, 1) == 1));
    out_ready = !bp || ($urandom_range(0, 1) == 1);
    res_valid = (core_q.size() > 0);
    if (res_valid) res_data = core_q[0];
    else           res_data = 128'd0;
    #1;
    if (blk_stall) begin
      chk("blk_valid_kept", blk_valid, 1'b1);
      chk("blk_stable", blk_data, prev_blk);
    end
    if (out_stall) begin
      chk("out_valid_kept", out_valid, 1'b1);
      chk("out_stable", out_data, prev_out);
    end
    if (busy && !in_ready && (in_cnt < in_words.size() || blk_cnt < exp_blk.size())) inr_low++;
    if (busy) busy_seen++;
    if (blk_valid && blk_rise_cyc < 0) blk_rise_cyc = cyc;
    if (out_valid && out_rise_cyc < 0) out_rise_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", busy, 1'b0);
    end
    blk_stall = blk_valid && !blk_ready;
    prev_blk  = blk_data;
    out_stall = out_valid && !out_ready;
    prev_out  = out_data;
    in_keep   = in_valid && !in_ready;
    if (in_valid && in_ready) begin
      in_cnt++;
      last_in_cyc = cyc;
    end
    if (res_valid && res_ready) begin
      void'(core_q.pop_front());
      if (res_fire_cyc < 0) res_fire_cyc = cyc;
    end
    if (blk_valid && blk_ready) begin
      if (blk_cnt < exp_blk.size()) chk("blk_data", blk_data, exp_blk[blk_cnt]);
      else                          chk("extra_blk", blk_cnt, exp_blk.size());
      last_blk = blk_data;
      core_q.push_back(blk_data ^ core_key);
      blk_cnt++;
    end
    if (out_valid && out_ready) begin
      if (out_cnt < exp_out.size()) chk("out_data", out_data, exp_out[out_cnt]);
      else                          chk("extra_out", out_cnt, exp_out.size());
      out_log.push_back(out_data);
      out_cnt++;
      last_out_cyc = cyc;
    end
  endtask

  task automatic begin_job(input int n, input bit use_fixed);
    logic [127:0] blk, res;
    logic [31:0]  w[4];
    in_words.delete(); exp_blk.delete(); exp_out.delete(); core_q.delete(); out_log.delete();
    in_cnt = 0; blk_cnt = 0; out_cnt = 0; done_cnt = 0; busy_seen = 0; inr_low = 0;
    last_out_cyc = -1; done_cyc = -1; last_in_cyc = -1;
    blk_rise_cyc = -1; res_fire_cyc = -1; out_rise_cyc = -1;
    for (int b = 0; b < n; b++) begin
      blk = 128'd0;
      for (int k = 0; k < 4; k++) begin
        w[k] = use_fixed ? fixed_w[k] : $urandom();
        in_words.push_back(w[k]);
        blk = (blk << 32) | {96'd0, w[k]};
      end
      exp_blk.push_back(blk);
      res = blk ^ core_key;
      for (int k = 0; k < 4; k++) exp_out.push_back(32'(res >> (96 - 32 * k)));
    end
    nb_ctl = 16'(n);
    start_ctl = 1'b1;
    cycle();
    start_cyc = cyc;
    start_ctl = 1'b0;
    cycle();
    chk("busy_rise", busy, (n != 0));
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) cycle();
    for (int i = 0; i < 4; i++) cycle();
  endtask

  task automatic end_checks(input vec_t v);
    chk("in_xfers", in_cnt, v.exp_xfers);
    chk("out_xfers", out_cnt, v.exp_xfers);
    chk("blk_xfers", blk_cnt, v.exp_xfers / 4);
    chk("done_count", done_cnt, v.exp_done);
    if (v.exp_inr_low >= 0) chk("in_ready_low", inr_low, v.exp_inr_low);
    if (v.n == 0) begin
      chk("busy_never", busy_seen, 0);
      chk("done_after_start", done_cyc, start_cyc + 1);
    end else begin
      chk("done_after_last_out", done_cyc, last_out_cyc + 1);
    end
  endtask

  vec_t vecs[6];
  vec_t v;

  initial begin
    vecs[0] = '{3, 1'b0, 1'b1, 12, 3, 1};
    vecs[1] = '{2, 1'b1, 1'b0, 8, -1, 1};
    vecs[2] = '{5, 1'b1, 1'b1, 20, -1, 1};
    vecs[3] = '{0, 1'b0, 1'b1, 0, 0, 1};
    vecs[4] = '{4, 1'b1, 1'b0, 16, -1, 1};
    vecs[5] = '{1, 1'b0, 1'b0, 4, -1, 1};
    fixed_w[0] = 32'h00112233; fixed_w[1] = 32'h44556677;
    fixed_w[2] = 32'h8899AABB; fixed_w[3] = 32'hCCDDEEFF;

    for (int i = 0; i < 3; i++) cycle();
    chk("reset_flags", {busy, done, in_ready, blk_valid, res_ready, out_valid}, 6'b0);
    chk("reset_blk_data", blk_data, 128'd0);
    chk("reset_out_data", out_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Known-answer block through a loopback core.
    core_key = 128'd0; bp = 1'b0; cont = 1'b1;
    begin_job(1, 1'b1);
    wait_done(200);
    chk("kat_block", last_blk, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    for (int k = 0; k < 4; k++) chk("kat_word", (k < out_log.size()) ? out_log[k] : 32'hX, fixed_w[k]);
    chk("kat_done", done_cnt, 1);
    chk("kat_done_timing", done_cyc, last_out_cyc + 1);
    chk("gather_latency", blk_rise_cyc, last_in_cyc + 1);
    chk("scatter_latency", out_rise_cyc, res_fire_cyc + 1);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      bp = v.bp; cont = v.cont;
      core_key = {$urandom(), $urandom(), $urandom(), $urandom()};
      begin_job(v.n, 1'b0);
      wait_done(800);
      end_checks(v);
    end

    // A start while busy must not change the job length.
    bp = 1'b0; cont = 1'b1;
    begin_job(2, 1'b0);
    for (int i = 0; i < 4; i++) cycle();
    nb_ctl = 16'd5; start_ctl = 1'b1;
    cycle();
    start_ctl = 1'b0;
    wait_done(400);
    chk("restart_out", out_cnt, 8);
    chk("restart_blk", blk_cnt, 2);
    chk("restart_done", done_cnt, 1);

    // Clear after two words of the second of four blocks aborts the job.
    begin_job(4, 1'b0);
    for (int i = 0; i < 100 && in_cnt < 6; i++) cycle();
    chk("clear_reach", in_cnt, 6);
    clear_ctl = 1'b1;
    cycle();
    clear_ctl = 1'b0;
    in_words.delete(); core_q.delete();
    in_keep = 1'b0; blk_stall = 1'b0; out_stall = 1'b0;
    done_cnt = 0;
    cycle();
    chk("clear_flags", {busy, done, in_ready, blk_valid, res_ready, out_valid}, 6'b0);
    chk("clear_blk_data", blk_data, 128'd0);
    chk("clear_out_data", out_data, 32'd0);
    for (int i = 0; i < 10; i++) cycle();
    chk("clear_no_done", done_cnt, 0);
    begin_job(1, 1'b0);
    wait_done(200);
    end_checks(vecs[5]);

    // enable=0 while a block is held: handshake still completes, input stays blocked.
    hold_blk = 1'b1;
    begin_job(2, 1'b0);
    for (int i = 0; i < 50 && !blk_valid; i++) cycle();
    en_ctl = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("hold_blk_valid", blk_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    hold_blk = 1'b0;
    cycle();
    chk("hold_handshake", blk_cnt, 1);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("disabled_in_ready", in_ready, 1'b0);
      chk("disabled_res_ready", res_ready, 1'b0);
    end
    en_ctl = 1'b1;
    cycle();
    chk("enabled_in_ready", in_ready, 1'b1);
    wait_done(400);
    chk("enable_out", out_cnt, 8);
    chk("enable_done", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_word_packer.md
# aes_word_packer

Width adapter between the HWPE streamers and the AES cipher core. It gathers 32-bit plaintext words from the source streamer into 128-bit blocks for the core. It then scatters each 128-bit ciphertext result back into 32-bit words for the sink streamer. A job is a fixed number of blocks, started by the AES control FSM, and ends with a one-cycle `done` pulse back to that FSM.

## Interface
Parameters:
- `WORD_W`, 32: streamer word width.
- `BLOCK_W`, 128: cipher block width. `BLOCK_W/WORD_W` (=4, `NWORDS`) must be an integer ≥ 2.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous clear. Same effect as reset.
- `enable` in 1: when 0, `in_ready` and `res_ready` are forced to 0.
- `start` in 1: one-cycle job start pulse.
- `nblocks` in 16: blocks per job. Sampled on `start`.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse when the job completes.
- `in_valid`/`in_ready` in/out 1, `in_data` in WORD_W: plaintext words from the source streamer.
- `blk_valid`/`blk_ready` out/in 1, `blk_data` out BLOCK_W: plaintext block to the core.
- `res_valid`/`res_ready` in/out 1, `res_data` in BLOCK_W: ciphertext block from the core.
- `out_valid`/`out_ready` out/in 1, `out_data` out WORD_W: ciphertext words to the sink streamer.

## Operation
- Handshake rule: a transfer occurs when `valid && ready` on a rising edge. A sender never drops `valid` or changes data until the transfer occurs.
- Word order: the first word of a block maps to bits [BLOCK_W-1 -: WORD_W] (MSW first). Scatter emits in the same order.
- `start` while `busy`=1 is ignored.
- On `start` with `nblocks`=0: `busy` stays 0, `done` pulses the next cycle, and no transfers occur.
- Gather FSM:
  - G_IDLE → G_FILL on an accepted `start`.
  - G_FILL: `in_ready`=`enable`. Each accepted word is shifted into the block register and the word counter is incremented.
  - On the `NWORDS`th word → G_HOLD.
  - G_HOLD: `blk_valid`=1, `in_ready`=0. On `blk_ready`, increment the gather block count, then go to G_FILL, or to G_IDLE if the count equals `nblocks`.
- Scatter FSM:
  - S_IDLE: `res_ready`=`busy && enable`. A `res_valid` handshake latches `res_data` and goes to S_DRAIN.
  - S_DRAIN: `out_valid`=1 and `out_data` = current word. Each `out_ready` handshake advances the word counter.
  - After the last word, increment the scatter block count → S_IDLE.
  - If the scatter block count then equals `nblocks`: `done`=1 for the next cycle and `busy`→0.
- `busy` rises the cycle after an accepted `start` (nblocks≠0) and falls together with the `done` pulse.
- `enable`=0 blocks new input only. A pending `blk_valid`/`out_valid` handshake still completes, so no `valid` is ever retracted.
- Extra `res_valid` after all blocks have been scattered is never accepted (`res_ready`=0 when `busy`=0).

## Timing
- Reset/clear values: FSMs in G_IDLE/S_IDLE, all counters 0, and `busy`, `done`, `in_ready`, `blk_valid`, `res_ready`, `out_valid` all 0. Data registers are 0.
- Gather latency: `blk_valid` rises the cycle after the 4th input word is accepted.
- Gather throughput: at most one block per 5 cycles (4 fill + 1 hold); no overlap.
- Scatter latency: `out_valid` rises the cycle after the `res_valid` handshake. 4 words follow at 1/cycle under constant `out_ready`.
- `done` rises the cycle after the final output word handshake.
- Word counters are log2(NWORDS) bits and wrap naturally. Block counters are 16 bits and are compared for equality with the latched `nblocks`.
- `clear` or reset mid-job aborts immediately. Partially gathered or drained blocks are discarded and no `done` is issued.

## Structure
- Shared package `aes_package` holds:
  - `AES_WORD_W`, `AES_BLOCK_W`
  - `aes_gather_state_t {G_IDLE,G_FILL,G_HOLD}`
  - `aes_scatter_state_t {S_IDLE,S_DRAIN}`
  - `ctrl_packer_t {start, clear, enable, nblocks}` and `flags_packer_t {busy, done}`, for the FSM connection.
- No sub-module. Gather and scatter are two independent processes in one module, sharing only `nblocks` and `busy`.

## Test plan
- nblocks=1, in words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF → `blk_data`=0x00112233_44556677_8899AABB_CCDDEEFF. A loopback core returns the same value, the words are emitted in the same order, and `done` pulses once the cycle after the 4th out handshake.
- nblocks=3 with continuous `in_valid` and `blk_ready`/`out_ready` held at 1 → exactly 12 in and 12 out transfers, `in_ready` low exactly 1 cycle per block, one `done`.
- Random `out_ready`/`blk_ready` backpressure (50%) → `blk_data`/`out_data` stable while valid and not ready, no lost or duplicated words.
- nblocks=0 start → `done` next cycle, `busy` never 1, no handshakes. A second `start` while `busy` is ignored (block count unchanged).
- `clear` after 2 words of block 2 of 4 → all outputs at reset values next cycle, no `done`. A new job with nblocks=1 then runs correctly.
- `enable`=0 during G_HOLD → `blk_valid` stays 1 and the handshake completes, `in_ready` stays 0 until `enable`=1.
